// File: rtl/serial_subtractor_if.sv
// ============================================================================
// serial_subtractor_if : operand/result bundle for the bit-serial subtractor
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             d_bit;
  logic             d_valid;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             done;

  modport master (
    output start, a, b, bin,
    input  busy, d_bit, d_valid, diff, bout, done
  );

  modport slave (
    input  start, a, b, bin,
    output busy, d_bit, d_valid, diff, bout, done
  );
endinterface

`default_nettype wire

// File: rtl/serial_subtractor.sv
// ============================================================================
// serial_subtractor : LSB-first bit-serial a - b - bin, one bit per clock
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_subtractor_if.slave  bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] diff_q;
  logic [CNT_W-1:0] cnt;
  logic             br;
  logic             bout_q;

  logic             cur_a;
  logic             cur_b;
  logic             d;
  logic             br_next;
  logic             last_bit;

  // Full-subtractor cell on the bit selected by the counter
  always_comb begin
    cur_a    = a_q[cnt];
    cur_b    = b_q[cnt];
    d        = cur_a ^ cur_b ^ br;
    br_next  = (~cur_a & cur_b) | (~(cur_a ^ cur_b) & br);
    last_bit = (cnt == CNT_W'(WIDTH - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = SHIFT;
      SHIFT:   if (last_bit)  state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      diff_q <= '0;
      cnt    <= '0;
      br     <= 1'b0;
      bout_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_q    <= bus.a;
            b_q    <= bus.b;
            br     <= bus.bin;
            cnt    <= '0;
            diff_q <= '0;
          end
        end
        SHIFT: begin
          diff_q[cnt] <= d;
          br          <= br_next;
          cnt         <= cnt + CNT_W'(1);
          if (last_bit) begin
            bout_q <= br_next;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.busy    = (state == SHIFT);
  assign bus.d_valid = (state == SHIFT);
  assign bus.d_bit   = (state == SHIFT) & d;
  assign bus.done    = (state == DONE);
  assign bus.diff    = diff_q;
  assign bus.bout    = bout_q;

endmodule

`default_nettype wire

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits (legal range 2..32).
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1 bit, request to begin a subtraction.
REQ-005 SHALL have port a, input, WIDTH bits, minuend; sampled only when start is accepted.
REQ-006 SHALL have port b, input, WIDTH bits, subtrahend; sampled only when start is accepted.
REQ-007 SHALL have port bin, input, 1 bit, borrow-in; sampled only when start is accepted.
REQ-008 SHALL have port busy, output, 1 bit, high while in SHIFT.
REQ-009 SHALL have port d_bit, output, 1 bit, serial difference bit, LSB first.
REQ-010 SHALL have port d_valid, output, 1 bit, qualifies d_bit.
REQ-011 SHALL have port diff, output, WIDTH bits, parallel result.
REQ-012 SHALL have port bout, output, 1 bit, final borrow-out.
REQ-013 SHALL have port done, output, 1 bit, one-cycle completion pulse.

Function
REQ-014 SHALL implement a three-state FSM: IDLE, SHIFT, DONE.
REQ-015 IDLE: start=1 at a rising edge SHALL load a, b and bin into internal registers, clear the bit counter, and enter SHIFT; start=0 SHALL keep IDLE.
REQ-016 SHIFT: each cycle SHALL apply a full-subtractor cell to bit i: d = a[i]^b[i]^br; br_next = (~a[i]&b[i]) | (~(a[i]^b[i])&br); br is initialised from bin.
REQ-017 SHIFT: d_valid SHALL be 1 and d_bit SHALL equal d for the current bit i, combinationally from registered state.
REQ-018 SHIFT: each rising edge SHALL write d into diff[i], update br, and increment the counter.
REQ-019 SHIFT SHALL last exactly WIDTH cycles; the edge that processes bit WIDTH-1 SHALL enter DONE and load bout with the final br.
REQ-020 DONE SHALL last exactly one cycle with done=1, then return to IDLE unconditionally.
REQ-021 Latency: with start sampled at edge 0, done SHALL be high in the cycle after edge WIDTH and diff/bout SHALL be final from that cycle onward.
REQ-022 diff and bout SHALL hold their values from DONE until the next accepted start; diff SHALL be cleared to 0 on that start.
REQ-023 start SHALL be ignored in SHIFT and DONE; a, b and bin changes outside acceptance SHALL not affect the operation.
REQ-024 Result SHALL equal (a - b - bin) mod 2^WIDTH; bout SHALL be 1 exactly when a < b + bin as unsigned integers.
REQ-025 busy, d_valid and done SHALL never be high in the same cycle as each other, except busy with d_valid.

Reset
REQ-026 rst_n=0 SHALL immediately, without waiting for clk, force state IDLE, counter 0, borrow register 0, diff=0, bout=0, busy=0, d_valid=0, d_bit=0, done=0.
REQ-027 Reset asserted mid-SHIFT SHALL abort the operation with no done pulse; the first start after deassertion SHALL run a complete operation.
REQ-028 The first rising edge after rst_n returns high SHALL be treated as a normal IDLE cycle.

Verification (WIDTH=8)
REQ-029 a=0x05, b=0x03, bin=0, start pulse -> d_bit stream 0,1,0,0,0,0,0,0; done 9 cycles after the start edge; diff=0x02, bout=0.
REQ-030 a=0x03, b=0x05, bin=0 -> diff=0xFE, bout=1.
REQ-031 a=0x00, b=0x00, bin=1 -> diff=0xFF, bout=1; a=0xFF, b=0xFF, bin=0 -> diff=0x00, bout=0.
REQ-032 start held high during SHIFT with a and b changed -> first result unaffected, done pulses once, next operation starts only from IDLE.
REQ-033 rst_n pulsed low at SHIFT cycle 4 -> all outputs 0 immediately, no done; new start a=0x10, b=0x01 -> diff=0x0F, bout=0.
REQ-034 Random a, b and bin over at least 1000 operations -> diff and bout match the REQ-024 model, and exactly one done pulse per accepted start.
